// File: rtl/req_ack_arbiter_pkg.sv
// req_arb_pkg: shared types and defaults for the req/ack round-robin arbiter.
package req_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAck = 2'd1,
        StRelease = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_MIN_ACK = 2;
    localparam int unsigned DEF_MAX_ACK = 4;

    // Width of the optional saturating statistics counters
    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/req_ack_arbiter_if.sv
// Requester/target handshake bundle for req_ack_arbiter.
// master: the arbiter side; slave: the requesters plus shared target.
// Stats signals exist only when REQ_ARB_STATS_EN is defined.
interface req_ack_arbiter_if
    import req_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_in;
    logic [NUM_REQ-1:0] ack_out;
    logic               err_out;
    logic [IDW-1:0]     grant_id;
    logic               busy;
    logic               tgt_req;
    logic               tgt_ack;
`ifdef REQ_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] stat_grants;
    logic [STAT_W-1:0]         stat_errs;
`endif

    modport master (
        input  req_in,
        input  tgt_ack,
        output ack_out,
        output err_out,
        output grant_id,
        output busy,
`ifdef REQ_ARB_STATS_EN
        output stat_grants,
        output stat_errs,
`endif
        output tgt_req
    );

    modport slave (
        output req_in,
        output tgt_ack,
        input  ack_out,
        input  err_out,
        input  grant_id,
        input  busy,
`ifdef REQ_ARB_STATS_EN
        input  stat_grants,
        input  stat_errs,
`endif
        input  tgt_req
    );

endinterface

// File: rtl/req_ack_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request bit
// at or above i_ptr, wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [IDW-1:0]     o_winner,
    output logic               o_valid
);

    // Scan NUM_REQ positions starting at the pointer; first hit wins
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[idx]) begin
                o_valid  = 1'b1;
                o_winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin sharing of one req/ack target among NUM_REQ
// requesters, with an enforced MIN_ACK..MAX_ACK acknowledge window. Early acks
// and timeouts complete to the owner with err_out set so the target cannot hang.
// Optional feature macro: REQ_ARB_STATS_EN (per-requester completion counters
// and a total error counter, 16-bit saturating).
module req_ack_arbiter
    import req_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MIN_ACK = DEF_MIN_ACK,
    parameter int unsigned MAX_ACK = DEF_MAX_ACK,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    req_ack_arbiter_if.master  bus
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ACK);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ACK);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_ACK + 1);

    arb_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant_id;
    logic [NUM_REQ-1:0] r_ack_out;
    logic               r_err_out;
    logic               r_busy;
    logic               r_tgt_req;

    logic [IDW-1:0]     w_winner;
    logic               w_valid;
    logic               w_done;
    logic               w_good;
    logic [IDW-1:0]     w_rr_next;
    logic [NUM_REQ-1:0] w_grant_oh;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_req    (bus.req_in),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // A transaction ends on any ack or on reaching the window limit without one
    assign w_done     = (r_state == StWaitAck) && (bus.tgt_ack || (r_cnt == MAX_C));
    assign w_good     = bus.tgt_ack && (r_cnt >= MIN_C) && (r_cnt <= MAX_C);
    assign w_rr_next  = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    // Arbiter FSM with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_ack_out  <= '0;
            r_err_out  <= 1'b0;
            r_busy     <= 1'b0;
            r_tgt_req  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        r_grant_id <= w_winner;
                        r_tgt_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (w_done) begin
                        r_tgt_req <= 1'b0;
                        r_ack_out <= w_grant_oh;
                        r_err_out <= !w_good;
                        r_cnt     <= '0;
                        r_state   <= StRelease;
                    end else if (r_cnt != SAT_C) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRelease: begin
                    // Single cycle that keeps tgt_req low at least 2 cycles
                    r_ack_out <= '0;
                    r_err_out <= 1'b0;
                    r_rr_ptr  <= w_rr_next;
                    r_busy    <= 1'b0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ack_out  = r_ack_out;
    assign bus.err_out  = r_err_out;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.tgt_req  = r_tgt_req;

`ifdef REQ_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_grants [NUM_REQ];
    logic [STAT_W-1:0] r_stat_errs;

    // Saturating completion counters, bumped on the edge that raises ack_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_stat_grants[i] <= '0;
            end
            r_stat_errs <= '0;
        end else if (w_done) begin
            if (r_stat_grants[r_grant_id] != '1) begin
                r_stat_grants[r_grant_id] <= r_stat_grants[r_grant_id] + 1'b1;
            end
            if (!w_good && (r_stat_errs != '1)) begin
                r_stat_errs <= r_stat_errs + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_out
        assign bus.stat_grants[g*STAT_W +: STAT_W] = r_stat_grants[g];
    end
    assign bus.stat_errs = r_stat_errs;
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed bench for req_ack_arbiter (NUM_REQ=4, MIN_ACK=2, MAX_ACK=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_req_ack_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    req_ack_arbiter_if #(.NUM_REQ(4)) bus ();

    req_ack_arbiter #(
        .NUM_REQ (4),
        .MIN_ACK (2),
        .MAX_ACK (4),
        .CNT_W   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       exp_tgt;
        logic [3:0] exp_ack_out;
        logic       exp_err;
        logic       exp_busy;
        logic [1:0] exp_gid;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic t, input logic [3:0] a,
                             input logic e, input logic b, input logic [1:0] g);
        check({tag, ".tgt_req"},  32'(bus.tgt_req),  32'(t));
        check({tag, ".ack_out"},  32'(bus.ack_out),  32'(a));
        check({tag, ".err_out"},  32'(bus.err_out),  32'(e));
        check({tag, ".busy"},     32'(bus.busy),     32'(b));
        check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(g));
    endtask

    initial begin
        // Single requester, early ack + stray acks, timeout + grant_id hold
        vecs[0]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[1]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1};
        vecs[6]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};
        vecs[8]  = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[10] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};
        vecs[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
        vecs[13] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
        vecs[14] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
        vecs[15] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
        vecs[16] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3};
        vecs[18] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3};

        bus.req_in  = '0;
        bus.tgt_ack = 1'b0;
        #1;
        check_all("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check_all("post_reset", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 19; i++) begin
            bus.req_in  = vecs[i].req;
            bus.tgt_ack = vecs[i].ack;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_tgt, vecs[i].exp_ack_out,
                      vecs[i].exp_err, vecs[i].exp_busy, vecs[i].exp_gid);
        end

        // Round-robin with all requesters held, target acks at cnt=2
        bus.req_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] g;
            g = 2'(i % 4);
            bus.tgt_ack = 1'b0;
            step();
            check($sformatf("rr%0d.grant", i), 32'(bus.grant_id), 32'(g));
            check($sformatf("rr%0d.tgt_req", i), 32'(bus.tgt_req), 32'd1);
            step();
            bus.tgt_ack = 1'b1;
            step();
            check($sformatf("rr%0d.ack_out", i), 32'(bus.ack_out), 32'(4'b0001 << g));
            check($sformatf("rr%0d.err_out", i), 32'(bus.err_out), 32'd0);
            bus.tgt_ack = 1'b0;
            step();
            check($sformatf("rr%0d.release", i), 32'({bus.busy, bus.ack_out}), 32'd0);
        end

        // Reset asserted mid-WAIT_ACK drops tgt_req without an edge
        bus.req_in = 4'b0100;
        step();
        step();
        check("mid.tgt_req", 32'(bus.tgt_req), 32'd1);
        check("mid.grant", 32'(bus.grant_id), 32'd2);
        reset = 1'b1;
        #1;
        check_all("async_reset", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        bus.req_in  = 4'b0000;
        bus.tgt_ack = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("after_reset%0d", i), 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        end
        bus.tgt_ack = 1'b0;

`ifdef REQ_ARB_STATS_EN
        check("stat.clear_g2", 32'(bus.stat_grants[2*16 +: 16]), 32'd0);
        check("stat.clear_err", 32'(bus.stat_errs), 32'd0);
        bus.req_in = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            bus.tgt_ack = 1'b0;
            step();
            step();
            bus.tgt_ack = 1'b1;
            step();
            bus.tgt_ack = 1'b0;
            step();
        end
        step();
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("stat.timeout_err", 32'(bus.err_out), 32'd1);
        bus.req_in = 4'b0000;
        step();
        check("stat.grants2", 32'(bus.stat_grants[2*16 +: 16]), 32'd6);
        check("stat.grants0", 32'(bus.stat_grants[0 +: 16]), 32'd0);
        check("stat.errs", 32'(bus.stat_errs), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
